// File: rtl/gray_monitor.sv
// Monitors a 3-bit Gray counter stream: tracks legal advances, wraps, illegal jumps and overflow edges.
// Optional GRAY_MON_RESYNC_EN lets the ERROR state resynchronise on the next valid sample.
module gray_monitor #(
  parameter int STEP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Valid,
  input  logic [2:0]        Gray,
  input  logic              Overflow,
  output logic [2:0]        Bin,
  output logic [STEP_W-1:0] Steps,
  output logic [3:0]        Wraps,
  output logic              Err,
  output logic              OvfPulse
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [STEP_W-1:0] STEP_MAX = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_reg, state_next;
  logic [2:0]        prev_reg, prev_next;
  logic [2:0]        bin_reg, bin_next;
  logic [STEP_W-1:0] steps_reg, steps_next;
  logic [3:0]        wraps_reg, wraps_next;
  logic              err_reg, err_next;
  logic              ovf_hist_reg, ovf_hist_next;
  logic              ovf_pulse_reg, ovf_pulse_next;

  function automatic logic [2:0] gray2bin(input logic [2:0] g);
    gray2bin = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  // Successor in the Gray sequence, found by stepping the binary value.
  function automatic logic [2:0] next_gray(input logic [2:0] g);
    logic [2:0] b;
    b = gray2bin(g) + 3'd1;
    next_gray = b ^ (b >> 1);
  endfunction

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    bin_next       = bin_reg;
    steps_next     = steps_reg;
    wraps_next     = wraps_reg;
    err_next       = err_reg;
    ovf_hist_next  = ovf_hist_reg;
    ovf_pulse_next = 1'b0;

    if (Clear) begin
      state_next    = ST_IDLE;
      prev_next     = 3'd0;
      bin_next      = 3'd0;
      steps_next    = '0;
      wraps_next    = 4'd0;
      err_next      = 1'b0;
      ovf_hist_next = 1'b0;
    end else if (Valid) begin
      // Overflow edge detection runs regardless of FSM state.
      ovf_hist_next  = Overflow;
      ovf_pulse_next = Overflow & ~ovf_hist_reg;

      case (state_reg)
        ST_IDLE: begin
          prev_next  = Gray;
          bin_next   = gray2bin(Gray);
          state_next = ST_TRACK;
        end
        ST_TRACK: begin
          if (Gray == prev_reg) begin
            state_next = ST_TRACK;
          end else if (Gray == next_gray(prev_reg)) begin
            prev_next = Gray;
            bin_next  = gray2bin(Gray);
            if (steps_reg != STEP_MAX)
              steps_next = steps_reg + STEP_ONE;
            if (prev_reg == 3'b100)
              wraps_next = wraps_reg + 4'd1;
          end else begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end
        end
        ST_ERROR: begin
`ifdef GRAY_MON_RESYNC_EN
          prev_next  = Gray;
          bin_next   = gray2bin(Gray);
          state_next = ST_TRACK;
`else
          state_next = ST_ERROR;
`endif
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      prev_reg      <= 3'd0;
      bin_reg       <= 3'd0;
      steps_reg     <= '0;
      wraps_reg     <= 4'd0;
      err_reg       <= 1'b0;
      ovf_hist_reg  <= 1'b0;
      ovf_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      bin_reg       <= bin_next;
      steps_reg     <= steps_next;
      wraps_reg     <= wraps_next;
      err_reg       <= err_next;
      ovf_hist_reg  <= ovf_hist_next;
      ovf_pulse_reg <= ovf_pulse_next;
    end
  end

  assign Bin      = bin_reg;
  assign Steps    = steps_reg;
  assign Wraps    = wraps_reg;
  assign Err      = err_reg;
  assign OvfPulse = ovf_pulse_reg;

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 Parameters SHALL be: STEP_W, default 8, width of the step counter.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Clear  input  1  synchronous clear of counters, error flag and FSM.
REQ-005 Valid  input  1  sample strobe; Gray and Overflow qualified when high.
REQ-006 Gray  input  3  gray code from the upstream 3-bit gray counter.
REQ-007 Overflow  input  1  sticky overflow flag from the upstream counter.
REQ-008 Bin  output  3  registered binary equivalent of last accepted Gray.
REQ-009 Steps  output  STEP_W  count of legal single advances, saturating.
REQ-010 Wraps  output  4  count of 100->000 wrap advances, modulo 16.
REQ-011 Err  output  1  sticky illegal-transition flag.
REQ-012 OvfPulse  output  1  one-cycle pulse on a sampled Overflow 0->1 edge.

Function
REQ-013 Legal sequence SHALL be 000,001,011,010,110,111,101,100, then back to 000.
REQ-014 FSM states SHALL be IDLE, TRACK and ERROR.
REQ-015 IDLE with Valid: capture Gray as prev, update Bin, go to TRACK; no Steps increment.
REQ-016 TRACK with Valid and Gray==prev: hold; no counter change.
REQ-017 TRACK with Valid and Gray==next(prev): prev<=Gray, Bin updated, Steps+1 (saturate at 2^STEP_W-1).
REQ-018 TRACK advance from 100 to 000 SHALL also increment Wraps; Wraps 15 wraps to 0.
REQ-019 TRACK with Valid and any other Gray: Err<=1, go to ERROR; Bin, Steps, Wraps and prev unchanged.
REQ-020 ERROR SHALL hold all counters and Bin; exit only by Reset, Clear, or per REQ-030.
REQ-021 Valid low: FSM, Bin and counters hold.
REQ-022 Bin SHALL be g[2], g[2]^g[1], g[2]^g[1]^g[0], visible one cycle after the accepting edge.
REQ-023 OvfPulse SHALL be high for exactly one cycle after a Valid sample with Overflow=1 whose previous Valid sample had Overflow=0; the sampled history starts at 0.
REQ-024 OvfPulse SHALL be evaluated in every FSM state, including ERROR.
REQ-025 Clear with Valid in the same cycle: Clear wins; the sample is discarded; next state IDLE.
REQ-026 Clear SHALL zero Bin, Steps, Wraps, Err, OvfPulse and the Overflow history.

Reset
REQ-027 Reset high SHALL immediately force IDLE; Bin, Steps, Wraps, Err, OvfPulse, prev and Overflow history all 0.
REQ-028 Reset asserted mid-sequence SHALL discard the in-flight sample; after release, the first Valid sample re-enters via IDLE.
REQ-029 Reset SHALL take priority over Clear and Valid.

Configuration
REQ-030 Macro GRAY_MON_RESYNC_EN defined: ERROR with Valid captures Gray as prev, updates Bin, and returns to TRACK; Err stays 1 until Clear/Reset.
REQ-031 Macro GRAY_MON_RESYNC_EN undefined: ERROR is absorbing until Clear or Reset.

Verification
REQ-032 Reset, then 9 Valid samples 000,001,011,010,110,111,101,100,000 -> Steps=8, Wraps=1, Bin=000, Err=0.
REQ-033 In TRACK at 001, Valid Gray=110 -> Err=1 next cycle; Steps/Bin frozen. Next Valid 011 -> without macro state stays ERROR; with macro Bin=010, TRACK.
REQ-034 Repeated Valid Gray=011 for 5 cycles after a legal arrival -> Steps unchanged; Overflow 0 then 1 on Valid -> OvfPulse high exactly 1 cycle.
REQ-035 Run 300 legal advances with STEP_W=8 -> Steps saturates at 255; Wraps=37 mod 16=5.
REQ-036 Clear and Valid asserted together mid-run, then Reset asynchronously between edges -> outputs 0 immediately; first post-reset Valid gives Steps=0, state TRACK.
